clk_div_ctrl: RTL and testbench

- Programmable clock-divider controller: produces a 50%-duty divided clock enable (clk_out) from clk, with run/stop sequencing and a valid/ready reconfiguration port.
- Period changes are applied only at period boundaries, so every produced period is exactly 2*half clk cycles and is never truncated.
- Feeds downstream tick consumers and the period-check assertions in the clock testbenches.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_core.sv | 49 ++++
 rtl/clk_div_ctrl.sv | 98 +++++++++
 tb/tb_clk_div_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock-divider controller.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int PCNT_W = 8;

  // A half-period of zero cannot produce a clock, so it is rejected at the port.
  function automatic logic is_valid_half(input logic [31:0] half);
    return half != 32'd0;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter and toggle flop. The first count cycle after run rises
// is an arming cycle, so the first low half is measured from a clean cnt=0.
module clk_div_core #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] half,
  output logic             clk_out,
  output logic             rise,
  output logic             fall,
  output logic             boundary
);

  logic [CNT_W-1:0] cnt;
  logic             armed;
  logic             at_end;
  logic             rise_now;

  // End of a half-period; boundary is the high->low toggle that closes a period.
  assign at_end   = run && armed && (cnt == half - CNT_W'(1));
  assign boundary = at_end && clk_out;
  assign rise_now = at_end && !clk_out;

  // Counter, toggle and registered edge pulses; everything clears when not running.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      armed   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      armed <= 1'b1;
      rise  <= rise_now;
      fall  <= boundary;
      if (!armed) begin
        cnt <= '0;
      end else if (at_end) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock-divider controller: run/stop sequencing, config handshake with a
// single pending slot, and a completed-period counter around clk_div_core.
// Handshake: a config transfers on any edge where cfg_valid && cfg_ready;
// cfg_ready is low exactly while a nonzero value waits in the pending slot.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int DEF_HALF = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic              cfg_ready,
  output logic              cfg_err,
  output logic              clk_out,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic              busy,
  output logic [CNT_W-1:0]  cur_half,
  output logic [PCNT_W-1:0] period_cnt,
  output logic [1:0]        fsm_state
);

  state_t           state;
  state_t           state_nx;
  logic             pend_v;
  logic [CNT_W-1:0] pend;
  logic             boundary;
  logic             accept;
  logic             run;

  assign cfg_ready = !pend_v;
  assign accept    = cfg_valid && cfg_ready;
  assign run       = (state != IDLE);
  assign busy      = run;
  assign fsm_state = state;

  clk_div_core #(.CNT_W(CNT_W)) u_core (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .half     (cur_half),
    .clk_out  (clk_out),
    .rise     (rise_pulse),
    .fall     (fall_pulse),
    .boundary (boundary)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state: STOP only retires at a period boundary; a returning en wins.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en) state_nx = RUN;
      RUN:     if (!en) state_nx = STOP;
      STOP: begin
        if (en)            state_nx = RUN;
        else if (boundary) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Config slot: load on accept, apply immediately when idle, else at a boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v   <= 1'b0;
      pend     <= '0;
      cur_half <= CNT_W'(DEF_HALF);
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= accept && !is_valid_half(32'(cfg_half));
      if (pend_v && (state == IDLE || boundary)) begin
        cur_half <= pend;
        pend_v   <= 1'b0;
      end
      if (accept && is_valid_half(32'(cfg_half))) begin
        pend   <= cfg_half;
        pend_v <= 1'b1;
      end
    end
  end

  // Completed-period counter, advanced on every falling toggle.
  always_ff @(posedge clk) begin
    if (rst)           period_cnt <= '0;
    else if (boundary) period_cnt <= period_cnt + PCNT_W'(1);
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: a period-position model checked every cycle, plus
// directed scenarios with hand-computed timing expectations.
module tb_clk_div_ctrl;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic             rise_pulse;
  logic             fall_pulse;
  logic             busy;
  logic [CNT_W-1:0] cur_half;
  logic [7:0]       period_cnt;
  logic [1:0]       fsm_state;

  int n_cmp = 0;
  int n_bad = 0;

  clk_div_ctrl #(.CNT_W(CNT_W), .DEF_HALF(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_half   (cfg_half),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .clk_out    (clk_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy),
    .cur_half   (cur_half),
    .period_cnt (period_cnt),
    .fsm_state  (fsm_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: position inside the current period, -1 while arming
  bit m_ok = 0;
  int m_mode, m_pos, m_half, m_pend, m_pc;
  bit m_pend_v, m_err, m_rise, m_fall, m_clk;
  logic [31:0] exp_q[$];

  task automatic model_step(input bit r, input bit e, input bit v, input int h);
    bit acc, bnd;
    int np, old_mode;
    if (r) begin
      m_mode = 0; m_pos = 0; m_half = 5; m_pend = 0; m_pend_v = 0;
      m_pc = 0; m_err = 0; m_rise = 0; m_fall = 0; m_clk = 0; m_ok = 1;
      return;
    end
    if (!m_ok) return;
    acc = v && !m_pend_v;
    bnd = 0; m_rise = 0; m_fall = 0;
    old_mode = m_mode;
    if (old_mode != 0) begin
      np = m_pos + 1;
      if (np == 2 * m_half) begin bnd = 1; np = 0; end
      m_rise = (np == m_half);
      m_fall = bnd;
      m_pos  = np;
    end
    case (old_mode)
      0: if (e) begin m_mode = 1; m_pos = -1; end
      1: if (!e) m_mode = 2;
      default: begin
        if (e) m_mode = 1;
        else if (bnd) begin m_mode = 0; m_pos = 0; end
      end
    endcase
    if (m_pend_v && (old_mode == 0 || bnd)) begin m_half = m_pend; m_pend_v = 0; end
    if (acc && h != 0) begin m_pend = h; m_pend_v = 1; end
    m_err = acc && (h == 0);
    if (bnd) m_pc = (m_pc + 1) % 256;
    m_clk = (m_mode != 0) && (m_pos >= m_half);
  endtask

  // scoreboard: model advances on each edge, DUT compared just after it
  always @(posedge clk) begin
    logic [31:0] exp_v, act_v;
    model_step(rst, en, cfg_valid, int'(cfg_half));
    if (m_ok) begin
      exp_q.push_back({m_clk, m_rise, m_fall, !m_pend_v, m_err, (m_mode != 0),
                       2'(m_mode), 16'(m_half), 8'(m_pc)});
    end
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {clk_out, rise_pulse, fall_pulse, cfg_ready, cfg_err, busy,
               fsm_state, cur_half, period_cnt};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle_model t=%0t act=%h exp=%h", $time, act_v, exp_v);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // driver tasks: bounded waits for the next rise / fall pulse
  task automatic wait_rise(output time t);
    bit found = 0;
    t = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (rise_pulse) begin found = 1; t = $time; end
    end
    if (!found) begin
      n_cmp++; n_bad++;
      $display("FAIL rise_timeout act=none exp=rise_pulse");
    end
  endtask

  task automatic wait_fall(output time t);
    bit found = 0;
    t = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (fall_pulse) begin found = 1; t = $time; end
    end
    if (!found) begin
      n_cmp++; n_bad++;
      $display("FAIL fall_timeout act=none exp=fall_pulse");
    end
  endtask

  task automatic offer(input int h);
    cfg_valid = 1'b1;
    cfg_half  = CNT_W'(h);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // directed stimulus
  initial begin
    time t0, t1, t2, t3, t4;
    int edges, pc0;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
    repeat (2) @(negedge clk);
    check("rst_clk_out", int'(clk_out), 0);
    check("rst_cur_half", int'(cur_half), 5);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_period_cnt", int'(period_cnt), 0);
    rst = 1'b0;

    // first rise six edges after en is sampled, then 10-cycle periods
    @(negedge clk);
    en = 1'b1;
    edges = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (clk_out) begin edges = k; break; end
    end
    check("first_rise_edges", edges, 6);
    t0 = $time;
    wait_rise(t1);
    check("period_10_a", int'(t1 - t0), 100);
    wait_rise(t2);
    check("period_10_b", int'(t2 - t1), 100);

    // new half 3 offered mid-high: held until the falling toggle
    repeat (2) @(negedge clk);
    offer(3);
    check("pend_ready_low", int'(cfg_ready), 0);
    wait_rise(t3);
    check("rise_after_apply3", int'(t3 - t2), 80);
    wait_rise(t4);
    check("period_6", int'(t4 - t3), 60);
    check("cur_half_3", int'(cur_half), 3);

    // zero half is rejected with a single err pulse
    offer(0);
    check("zero_err", int'(cfg_err), 1);
    check("zero_ready", int'(cfg_ready), 1);
    check("zero_half_kept", int'(cur_half), 3);
    @(negedge clk);
    check("zero_err_clear", int'(cfg_err), 0);

    // back to half 5
    offer(5);
    wait_fall(t0);
    wait_fall(t0);
    check("cur_half_5", int'(cur_half), 5);

    // drop en in the low phase: the period completes, then idle
    en = 1'b0;
    wait_fall(t1);
    check("stop_full_period", int'(t1 - t0), 100);
    check("stop_busy_low", int'(busy), 0);
    check("stop_clk_low", int'(clk_out), 0);

    // en returns during STOP: no gap in the period train
    en = 1'b1;
    wait_fall(t0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    wait_fall(t1);
    check("resume_no_gap", int'(t1 - t0), 100);
    check("resume_busy", int'(busy), 1);

    // config accepted on the falling-toggle cycle waits one more period
    wait_rise(t0);
    repeat (4) @(negedge clk);
    offer(2);
    check("accept_on_fall", int'(fall_pulse), 1);
    check("accept_on_fall_pending", int'(cfg_ready), 0);
    t2 = $time;
    wait_fall(t3);
    check("still_period_10", int'(t3 - t2), 100);
    wait_fall(t4);
    check("period_4", int'(t4 - t3), 40);

    // 256 periods return period_cnt to its start; explicit 255 -> 0 wrap
    pc0 = int'(period_cnt);
    repeat (256) wait_fall(t0);
    check("pc_256_periods", int'(period_cnt), pc0);
    for (int k = 0; k < 300 && period_cnt != 8'd255; k++) wait_fall(t0);
    wait_fall(t0);
    check("pc_wrap_zero", int'(period_cnt), 0);

    // reset mid-high with a config pending
    wait_rise(t0);
    offer(7);
    check("rst_pend_ready", int'(cfg_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_clk_out", int'(clk_out), 0);
    check("mid_rst_cur_half", int'(cur_half), 5);
    check("mid_rst_ready", int'(cfg_ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_pc", int'(period_cnt), 0);
    en = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
